ttt_game_ctrl: RTL and testbench

//  Game sequencer for the tic-tac-toe board. Sits between the keypad scanner and the 7-seg/dot-matrix display logic.

---
 rtl/ttt_game_ctrl_if.sv | 46 ++++
 rtl/ttt_game_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl_if
//   Bundles the keypad-side inputs and the display-side outputs of the
//   tic-tac-toe game sequencer.
//
//   master : keypad/DIP side (drives start, key_valid, key_code; observes
//            board and status)
//   slave  : the game sequencer itself
//
//   start         level, 1 = game mode requested
//   key_valid     one-cycle strobe qualifying key_code
//   key_code[3:0] 1..9 cell, 10 '*', 11 '#', others ignored
//   board[17:0]   cell n at [19-2n:18-2n]; hi bit = O stone, lo bit = X stone
//   turn_o        1 = O to move, 0 = X to move
//   result[1:0]   00 playing/idle, 01 X wins, 10 O wins, 11 draw
//   in_game       1 while a game is active or finished (not on main screen)
//   view_right    dot-matrix window select
//   move_cnt[3:0] stones placed, 0..9
//   move_err      one-cycle pulse, move to an occupied cell
//   timeout_pulse one-cycle pulse, turn forfeited by timeout
// ---------------------------------------------------------------------------
interface ttt_game_ctrl_if;
   logic        start;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [17:0] board;
   logic        turn_o;
   logic [1:0]  result;
   logic        in_game;
   logic        view_right;
   logic [3:0]  move_cnt;
   logic        move_err;
   logic        timeout_pulse;

   modport master (
      output start, key_valid, key_code,
      input  board, turn_o, result, in_game, view_right, move_cnt,
             move_err, timeout_pulse
   );

   modport slave (
      input  start, key_valid, key_code,
      output board, turn_o, result, in_game, view_right, move_cnt,
             move_err, timeout_pulse
   );
endinterface

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
//   Tic-tac-toe game sequencer. Takes decoded key codes from the keypad
//   scanner, places stones on the 18-bit board register read by the display
//   ROM, alternates turns, detects win/draw and forfeits a turn when the
//   per-move timer expires.
//
//   Parameters
//     MOVE_TIMEOUT  clk cycles allowed per move; 0 disables the timeout
//     CNT_W         timer width; must hold MOVE_TIMEOUT-1
//
//   Ports
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   ttt_game_ctrl_if.slave (start/key inputs, board/status outputs)
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
   parameter int unsigned MOVE_TIMEOUT = 250_000_000,
   parameter int unsigned CNT_W        = 28
) (
   input  logic           clk,
   input  logic           rst,
   ttt_game_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic             TIMEOUT_EN = (MOVE_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST    =
      CNT_W'((MOVE_TIMEOUT == 0) ? 0 : MOVE_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [17:0]        board_q, board_d;
   logic               turn_q, turn_d;
   logic [1:0]         result_q, result_d;
   logic               view_q, view_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               to_q, to_d;
   logic [CNT_W-1:0]   timer_q, timer_d;

   logic               in_game;

   // ------------------------------------------------------------------
   // Key decode and board views
   // ------------------------------------------------------------------
   logic               key_cell, key_star, key_hash;
   logic [3:0]         cell_idx;
   logic [8:0]         cell_oh;
   logic [8:0]         x_mask, o_mask, mover_mask;
   logic               occupied, place, mover_win, board_full, timeout_hit;

   // All eight winning lines, cells indexed 0..8 row-major.
   function automatic logic has_line(input logic [8:0] m);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, so no path can leave it unassigned and infer a latch.
      key_cell = bus.key_valid && (bus.key_code >= 4'd1) && (bus.key_code <= 4'd9);
      key_star = bus.key_valid && (bus.key_code == 4'd10);
      key_hash = bus.key_valid && (bus.key_code == 4'd11);
      cell_idx = bus.key_code - 4'd1;
      cell_oh  = key_cell ? (9'b1 << cell_idx) : 9'b0;

      x_mask = '0;
      o_mask = '0;
      for (int i = 0; i < 9; i++) begin
         x_mask[i] = board_q[16-2*i];
         o_mask[i] = board_q[17-2*i];
      end

      mover_mask  = turn_q ? o_mask : x_mask;
      occupied    = |(cell_oh & (x_mask | o_mask));
      place       = (state_q == ST_PLAY) && key_cell && !occupied;
      mover_win   = has_line(mover_mask);
      board_full  = (cnt_q == 4'd9);
      timeout_hit = TIMEOUT_EN && (timer_q == TO_LAST);
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (!bus.start) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_PLAY;
            ST_PLAY:  if (place) state_d = ST_CHECK;
            ST_CHECK: state_d = (mover_win || board_full) ? ST_OVER : ST_PLAY;
            ST_OVER:  state_d = ST_OVER;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_game = (state_q != ST_IDLE);
   end

   // ------------------------------------------------------------------
   // Game datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      board_d  = board_q;
      turn_d   = turn_q;
      result_d = result_q;
      view_d   = view_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      to_d     = 1'b0;
      timer_d  = timer_q;

      if (!bus.start) begin
         // Abort to the main screen clears the game exactly like reset.
         board_d  = '0;
         turn_d   = 1'b0;
         result_d = 2'b00;
         view_d   = 1'b0;
         cnt_d    = '0;
         timer_d  = '0;
      end else begin
         if (state_q != ST_IDLE) begin
            if (key_star) view_d = 1'b0;
            if (key_hash) view_d = 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               timer_d = '0;
            end

            ST_PLAY: begin
               if (place) begin
                  // An accepted move beats a timeout falling in the same cycle.
                  for (int i = 0; i < 9; i++) begin
                     if (cell_oh[i]) begin
                        board_d[17-2*i] = turn_q;
                        board_d[16-2*i] = !turn_q;
                     end
                  end
                  cnt_d   = cnt_q + 4'd1;
                  timer_d = '0;
               end else begin
                  if (key_cell) err_d = 1'b1;  // key_cell without place means occupied
                  if (timeout_hit) begin
                     to_d    = 1'b1;
                     turn_d  = !turn_q;
                     timer_d = '0;
                  end else if (TIMEOUT_EN) begin
                     timer_d = timer_q + CNT_W'(1);
                  end
               end
            end

            ST_CHECK: begin
               // Only the player who just moved can have completed a line.
               if (mover_win) begin
                  result_d = turn_q ? 2'b10 : 2'b01;
               end else if (board_full) begin
                  result_d = 2'b11;
               end else begin
                  turn_d  = !turn_q;
                  timer_d = '0;
               end
            end

            ST_OVER: begin
               // Board, result and count stay frozen until abort or reset.
            end

            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= ST_IDLE;
         board_q  <= '0;
         turn_q   <= 1'b0;
         result_q <= 2'b00;
         view_q   <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         turn_q   <= turn_d;
         result_q <= result_d;
         view_q   <= view_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         to_q     <= to_d;
         timer_q  <= timer_d;
      end
   end

   assign bus.board         = board_q;
   assign bus.turn_o        = turn_q;
   assign bus.result        = result_q;
   assign bus.in_game       = in_game;
   assign bus.view_right    = view_q;
   assign bus.move_cnt      = cnt_q;
   assign bus.move_err      = err_q;
   assign bus.timeout_pulse = to_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_game_ctrl
//   Self-checking bench for ttt_game_ctrl with a short move timeout.
//   Table rows are single actions (start level plus optional key); each row's
//   expected outputs are queued when driven and compared once the move has
//   travelled through PLAY and CHECK. Hand-written sequences cover the key
//   dropped in CHECK, reset in CHECK and the timeout corner cases.
// ---------------------------------------------------------------------------
module tb_ttt_game_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ttt_game_ctrl_if gif ();

   ttt_game_ctrl #(
      .MOVE_TIMEOUT (16),
      .CNT_W        (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (gif)
   );

   typedef struct {
      logic        st;
      logic        kv;
      logic [3:0]  code;
      logic [17:0] board;
      logic        turn;
      logic [1:0]  result;
      logic [3:0]  cnt;
      logic        ig;
      logic        view;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic kv, input logic [3:0] code,
                               input logic [17:0] b, input logic t, input logic [1:0] r,
                               input logic [3:0] c, input logic ig, input logic v,
                               input logic e);
      vec_t x;
      x.st = st; x.kv = kv; x.code = code; x.board = b; x.turn = t;
      x.result = r; x.cnt = c; x.ig = ig; x.view = v; x.err = e;
      return x;
   endfunction

   // One table row: drive for one cycle, sample move_err one cycle later,
   // compare the settled outputs two cycles after the key.
   task automatic run_vec(input vec_t v, input int idx);
      vec_t e;
      logic err_seen;
      @(negedge clk);
      gif.start     = v.st;
      gif.key_valid = v.kv;
      gif.key_code  = v.code;
      exp_q.push_back(v);
      @(negedge clk);
      gif.key_valid = 1'b0;
      gif.key_code  = 4'd0;
      err_seen      = gif.move_err;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d board", idx),  32'(gif.board),      32'(e.board));
      check($sformatf("v%0d turn", idx),   32'(gif.turn_o),     32'(e.turn));
      check($sformatf("v%0d result", idx), 32'(gif.result),     32'(e.result));
      check($sformatf("v%0d cnt", idx),    32'(gif.move_cnt),   32'(e.cnt));
      check($sformatf("v%0d in_game", idx),32'(gif.in_game),    32'(e.ig));
      check($sformatf("v%0d view", idx),   32'(gif.view_right), 32'(e.view));
      check($sformatf("v%0d err", idx),    32'(err_seen),       32'(e.err));
      check($sformatf("v%0d err_width", idx), 32'(gif.move_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_to;

      gif.start     = 1'b0;
      gif.key_valid = 1'b0;
      gif.key_code  = 4'd0;

      // ---------------- table -----------------
      // X row win 1,4,2,5,3 then OVER behaviour, abort, view key in IDLE
      vecs.push_back(mk(1,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,0,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,0,0));
      vecs.push_back(mk(1,1,4'd4,  18'b01_00_00_10_00_00_00_00_00, 0,2'b00,4'd2,1,0,0));
      vecs.push_back(mk(1,1,4'd2,  18'b01_01_00_10_00_00_00_00_00, 1,2'b00,4'd3,1,0,0));
      vecs.push_back(mk(1,1,4'd5,  18'b01_01_00_10_10_00_00_00_00, 0,2'b00,4'd4,1,0,0));
      vecs.push_back(mk(1,1,4'd3,  18'b01_01_01_10_10_00_00_00_00, 0,2'b01,4'd5,1,0,0));
      vecs.push_back(mk(1,1,4'd6,  18'b01_01_01_10_10_00_00_00_00, 0,2'b01,4'd5,1,0,0));
      vecs.push_back(mk(1,1,4'd11, 18'b01_01_01_10_10_00_00_00_00, 0,2'b01,4'd5,1,1,0));
      vecs.push_back(mk(0,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));
      vecs.push_back(mk(0,1,4'd11, 18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));
      // Draw 1,2,3,5,4,6,8,7,9 then view keys in OVER
      vecs.push_back(mk(1,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,0,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,0,0));
      vecs.push_back(mk(1,1,4'd2,  18'b01_10_00_00_00_00_00_00_00, 0,2'b00,4'd2,1,0,0));
      vecs.push_back(mk(1,1,4'd3,  18'b01_10_01_00_00_00_00_00_00, 1,2'b00,4'd3,1,0,0));
      vecs.push_back(mk(1,1,4'd5,  18'b01_10_01_00_10_00_00_00_00, 0,2'b00,4'd4,1,0,0));
      vecs.push_back(mk(1,1,4'd4,  18'b01_10_01_01_10_00_00_00_00, 1,2'b00,4'd5,1,0,0));
      vecs.push_back(mk(1,1,4'd6,  18'b01_10_01_01_10_10_00_00_00, 0,2'b00,4'd6,1,0,0));
      vecs.push_back(mk(1,1,4'd8,  18'b01_10_01_01_10_10_00_01_00, 1,2'b00,4'd7,1,0,0));
      vecs.push_back(mk(1,1,4'd7,  18'b01_10_01_01_10_10_10_01_00, 0,2'b00,4'd8,1,0,0));
      vecs.push_back(mk(1,1,4'd9,  18'b01_10_01_01_10_10_10_01_01, 0,2'b11,4'd9,1,0,0));
      vecs.push_back(mk(1,1,4'd11, 18'b01_10_01_01_10_10_10_01_01, 0,2'b11,4'd9,1,1,0));
      vecs.push_back(mk(1,1,4'd10, 18'b01_10_01_01_10_10_10_01_01, 0,2'b11,4'd9,1,0,0));
      vecs.push_back(mk(0,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));
      // Occupied cell, ignored codes, view keys in PLAY
      vecs.push_back(mk(1,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,0,0));
      vecs.push_back(mk(1,1,4'd11, 18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,1,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,1,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,1,1));
      vecs.push_back(mk(1,1,4'd0,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,1,0));
      vecs.push_back(mk(1,1,4'd12, 18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,1,0));
      vecs.push_back(mk(1,1,4'd10, 18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,0,0));
      vecs.push_back(mk(0,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));
      // O diagonal win 1,5,2,3,9,7
      vecs.push_back(mk(1,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,0,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,0,0));
      vecs.push_back(mk(1,1,4'd5,  18'b01_00_00_00_10_00_00_00_00, 0,2'b00,4'd2,1,0,0));
      vecs.push_back(mk(1,1,4'd2,  18'b01_01_00_00_10_00_00_00_00, 1,2'b00,4'd3,1,0,0));
      vecs.push_back(mk(1,1,4'd3,  18'b01_01_10_00_10_00_00_00_00, 0,2'b00,4'd4,1,0,0));
      vecs.push_back(mk(1,1,4'd9,  18'b01_01_10_00_10_00_00_00_01, 1,2'b00,4'd5,1,0,0));
      vecs.push_back(mk(1,1,4'd7,  18'b01_01_10_00_10_00_10_00_01, 1,2'b10,4'd6,1,0,0));
      vecs.push_back(mk(0,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));
      // X wins on the ninth move: 1,3,2,4,5,7,6,8,9 (diagonal 1-5-9)
      vecs.push_back(mk(1,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,1,0,0));
      vecs.push_back(mk(1,1,4'd1,  18'b01_00_00_00_00_00_00_00_00, 1,2'b00,4'd1,1,0,0));
      vecs.push_back(mk(1,1,4'd3,  18'b01_00_10_00_00_00_00_00_00, 0,2'b00,4'd2,1,0,0));
      vecs.push_back(mk(1,1,4'd2,  18'b01_01_10_00_00_00_00_00_00, 1,2'b00,4'd3,1,0,0));
      vecs.push_back(mk(1,1,4'd4,  18'b01_01_10_10_00_00_00_00_00, 0,2'b00,4'd4,1,0,0));
      vecs.push_back(mk(1,1,4'd5,  18'b01_01_10_10_01_00_00_00_00, 1,2'b00,4'd5,1,0,0));
      vecs.push_back(mk(1,1,4'd7,  18'b01_01_10_10_01_00_10_00_00, 0,2'b00,4'd6,1,0,0));
      vecs.push_back(mk(1,1,4'd6,  18'b01_01_10_10_01_01_10_00_00, 1,2'b00,4'd7,1,0,0));
      vecs.push_back(mk(1,1,4'd8,  18'b01_01_10_10_01_01_10_10_00, 0,2'b00,4'd8,1,0,0));
      vecs.push_back(mk(1,1,4'd9,  18'b01_01_10_10_01_01_10_10_01, 0,2'b01,4'd9,1,0,0));
      vecs.push_back(mk(0,0,4'd0,  18'b00_00_00_00_00_00_00_00_00, 0,2'b00,4'd0,0,0,0));

      // ---------------- reset state -----------------
      repeat (3) @(negedge clk);
      check("rst board",   32'(gif.board),         32'd0);
      check("rst turn",    32'(gif.turn_o),        32'd0);
      check("rst result",  32'(gif.result),        32'd0);
      check("rst in_game", 32'(gif.in_game),       32'd0);
      check("rst view",    32'(gif.view_right),    32'd0);
      check("rst cnt",     32'(gif.move_cnt),      32'd0);
      check("rst err",     32'(gif.move_err),      32'd0);
      check("rst to",      32'(gif.timeout_pulse), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // ---------------- key dropped in CHECK, reset in CHECK -----------------
      @(negedge clk);
      gif.start = 1'b1;
      @(negedge clk);
      gif.key_valid = 1'b1; gif.key_code = 4'd11;
      @(negedge clk);
      gif.key_code = 4'd1;                     // accepted in PLAY
      @(negedge clk);
      gif.key_code = 4'd2;                     // arrives while in CHECK
      @(negedge clk);
      gif.key_valid = 1'b0; gif.key_code = 4'd0;
      check("chk_drop err", 32'(gif.move_err), 32'd0);
      @(negedge clk);
      check("chk_drop board", 32'(gif.board), 32'(18'b01_00_00_00_00_00_00_00_00));
      check("chk_drop cnt",   32'(gif.move_cnt), 32'd1);
      check("chk_drop turn",  32'(gif.turn_o), 32'd1);
      gif.key_valid = 1'b1; gif.key_code = 4'd2;
      @(negedge clk);                          // now in CHECK
      gif.key_valid = 1'b0; gif.key_code = 4'd0;
      check("pre_rst board", 32'(gif.board), 32'(18'b01_10_00_00_00_00_00_00_00));
      rst = 1'b1;
      @(negedge clk);
      check("chk_rst board",   32'(gif.board),         32'd0);
      check("chk_rst turn",    32'(gif.turn_o),        32'd0);
      check("chk_rst result",  32'(gif.result),        32'd0);
      check("chk_rst in_game", 32'(gif.in_game),       32'd0);
      check("chk_rst view",    32'(gif.view_right),    32'd0);
      check("chk_rst cnt",     32'(gif.move_cnt),      32'd0);
      rst = 1'b0;
      gif.start = 1'b0;
      @(negedge clk);

      // ---------------- timeout -----------------
      gif.start = 1'b1;
      first_to  = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (gif.timeout_pulse) begin
            first_to = i;
            break;
         end
      end
      check("to first_pulse_cycle", 32'(first_to), 32'd17);
      check("to turn", 32'(gif.turn_o), 32'd1);
      check("to board", 32'(gif.board), 32'd0);
      @(negedge clk);
      check("to pulse_width", 32'(gif.timeout_pulse), 32'd0);
      repeat (14) @(negedge clk);
      gif.key_valid = 1'b1; gif.key_code = 4'd5;   // lands on the timeout cycle
      @(negedge clk);
      gif.key_valid = 1'b0; gif.key_code = 4'd0;
      check("to_move pulse", 32'(gif.timeout_pulse), 32'd0);
      check("to_move board", 32'(gif.board), 32'(18'b00_00_00_00_10_00_00_00_00));
      check("to_move cnt",   32'(gif.move_cnt), 32'd1);
      @(negedge clk);
      check("to_move pulse2", 32'(gif.timeout_pulse), 32'd0);
      check("to_move turn",   32'(gif.turn_o), 32'd0);
      gif.start = 1'b0;
      @(negedge clk);
      check("abort in_game", 32'(gif.in_game), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
